occupancy_counter: RTL
======================

# occupancy_counter

Downstream consumer of the parking-lot entry/exit detector. Takes its single-cycle `inc`/`dec` pulses and keeps a saturating count of cars in the lot. Publishes free spaces, empty/full flags, a hysteretic lot-status state (OPEN / NEAR / FULL) for the signage and gate logic, and sticky overflow/underflow error flags.

## Interface
Parameters:
- `CAPACITY`, 16: number of spaces; legal range ≥ 2.
- `NEAR_FULL`, 14: count at or above which the lot enters NEAR; 1 ≤ NEAR_FULL < CAPACITY.
- `HYST`, 2: hysteresis depth for leaving NEAR; 1 ≤ HYST ≤ NEAR_FULL.
- `W`: derived localparam, `$clog2(CAPACITY+1)`.

Ports:
- `clk`  in  1  sole clock; everything is on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset. Assertion clears all state immediately; deassertion is synchronised externally.
- `inc`  in  1  car-entered pulse from the detector, one cycle wide.
- `dec`  in  1  car-exited pulse from the detector, one cycle wide.
- `clr_err`  in  1  clears both sticky error flags.
- `count`  out  W  cars currently in the lot.
- `free`  out  W  `CAPACITY - count`.
- `empty`  out  1  `count == 0`.
- `full`  out  1  `count == CAPACITY`.
- `lot_state`  out  2  `lot_state_t`: LOT_OPEN, LOT_NEAR or LOT_FULL.
- `overflow_err`  out  1  sticky; an `inc` arrived while full.
- `underflow_err`  out  1  sticky; a `dec` arrived while empty.

## Operation
- Reset values: count=0, free=CAPACITY, empty=1, full=0, lot_state=LOT_OPEN, both errors 0.
- The next count `cnt_nxt` is decided per cycle as follows:
  - `inc & ~dec`: count+1, unless full. When full, hold and set `overflow_err`.
  - `dec & ~inc`: count−1, unless empty. When empty, hold and set `underflow_err`.
  - `inc & dec`: hold; no error at any count, including 0 and CAPACITY.
  - Neither: hold.
- Count arithmetic is W-bit unsigned. It saturates and never wraps.
- Error flags:
  - `clr_err` clears both flags.
  - If a new error and `clr_err` occur in the same cycle, the set wins.
- Lot-state FSM is evaluated on `cnt_nxt`, not on `count`:
  - LOT_OPEN → LOT_FULL if cnt_nxt == CAPACITY; else → LOT_NEAR if cnt_nxt ≥ NEAR_FULL.
  - LOT_NEAR → LOT_FULL if cnt_nxt == CAPACITY; else → LOT_OPEN if cnt_nxt ≤ NEAR_FULL − HYST.
  - LOT_FULL → LOT_NEAR if cnt_nxt < CAPACITY (count only moves by 1 per cycle, so NEAR is always the exit).
  - No other transitions. An unreachable encoding recovers to LOT_OPEN.
- `free`, `empty` and `full` are registered from `cnt_nxt`, so they never lag `count`.

## Timing
- Latency: an `inc`/`dec` sampled at edge N is reflected on every output after edge N. All outputs are registered, with no combinational input-to-output paths.
- Sustained back-to-back pulses, one per cycle, are accepted without loss.
- Reset mid-operation: all outputs take their reset values asynchronously. Pulses present while `reset_n` is low are discarded. The first edge after release samples inputs normally.
- `clr_err` takes effect on the next edge. Errors are visible for at least one cycle before they can be cleared.

## Structure
- Shared package `parking_pkg` holds:
  - `lot_state_t` as a 2-bit enum: LOT_OPEN=0, LOT_NEAR=1, LOT_FULL=2.
  - Default values for CAPACITY, NEAR_FULL and HYST, shared with the detector's top level.
- One sub-module is natural: `lot_status_fsm`. It takes `cnt_nxt` plus the parameters and outputs `lot_state`. The counter datapath and error logic stay in `occupancy_counter`.

## Test plan
All scenarios use CAPACITY=4, NEAR_FULL=3, HYST=2.
1. Reset: drive count to 3, pull `reset_n` low between edges → immediately count=0, free=4, empty=1, lot_state=OPEN, errors 0. Pulses during reset are ignored.
2. Fill: four `inc` pulses, back-to-back → count 1, 2, 3, 4. lot_state becomes NEAR when count reaches 3 and FULL when it reaches 4. At the end, full=1 and free=0.
3. Overflow/underflow:
   - `inc` at count=4 → count stays 4 and overflow_err=1 after the edge.
   - Drain to 0, then `dec` → count stays 0 and underflow_err=1.
   - `clr_err` → both flags 0 next cycle.
4. Hysteresis: from count 4, one `dec` per cycle → 3 (NEAR), 2 (NEAR), 1 (OPEN). Then `inc` → 2 (OPEN), `inc` → 3 (NEAR).
5. Simultaneous `inc & dec` at count 0, count 2 and count 4 → count unchanged, no error flags, lot_state unchanged.
6. `clr_err` in the same cycle as an overflowing `inc` at count=4 → overflow_err=1 after the edge. A second `clr_err` alone → 0.

Source files
------------

// File: rtl/parking_pkg.sv
// Shared types and default sizing for the parking-lot occupancy logic.
package parking_pkg;

  // Lot status shown on the signage and used by the gate logic.
  typedef enum logic [1:0] {
    LOT_OPEN = 2'd0,
    LOT_NEAR = 2'd1,
    LOT_FULL = 2'd2
  } lot_state_t;

  // Defaults shared with the detector's top level.
  localparam int DEF_CAPACITY  = 16;
  localparam int DEF_NEAR_FULL = 14;
  localparam int DEF_HYST      = 2;

endpackage

// File: rtl/occupancy_counter_if.sv
// Pulse inputs and status outputs of the occupancy counter, bundled as one port.
interface occupancy_counter_if
  import parking_pkg::*;
#(
  parameter int W = 5
) ();

  logic         inc;
  logic         dec;
  logic         clr_err;
  logic [W-1:0] count;
  logic [W-1:0] free;
  logic         empty;
  logic         full;
  lot_state_t   lot_state;
  logic         overflow_err;
  logic         underflow_err;

  // Detector / supervisor side: issues pulses, observes status.
  modport master (
    output inc, dec, clr_err,
    input  count, free, empty, full, lot_state, overflow_err, underflow_err
  );

  // Counter side: consumes pulses, publishes status.
  modport slave (
    input  inc, dec, clr_err,
    output count, free, empty, full, lot_state, overflow_err, underflow_err
  );

endinterface

// File: rtl/lot_status_fsm.sv
// Hysteretic OPEN/NEAR/FULL status, evaluated on the next count value so it
// changes on the same edge as the count itself.
module lot_status_fsm
  import parking_pkg::*;
#(
  parameter int CAPACITY  = DEF_CAPACITY,
  parameter int NEAR_FULL = DEF_NEAR_FULL,
  parameter int HYST      = DEF_HYST,
  parameter int W         = $clog2(CAPACITY + 1)
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] i_cnt_nxt,
  output lot_state_t   o_lot_state
);

  localparam logic [W-1:0] CAP_W   = W'(CAPACITY);
  localparam logic [W-1:0] NEAR_W  = W'(NEAR_FULL);
  // Count at or below which NEAR falls back to OPEN.
  localparam logic [W-1:0] LEAVE_W = W'(NEAR_FULL - HYST);

  lot_state_t r_state;
  lot_state_t w_state_next;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= LOT_OPEN;
    else          r_state <= w_state_next;
  end

  // Next-state decision; FULL is only ever left through NEAR since the count
  // moves by at most one per cycle.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      LOT_OPEN: begin
        if (i_cnt_nxt == CAP_W)       w_state_next = LOT_FULL;
        else if (i_cnt_nxt >= NEAR_W) w_state_next = LOT_NEAR;
      end
      LOT_NEAR: begin
        if (i_cnt_nxt == CAP_W)        w_state_next = LOT_FULL;
        else if (i_cnt_nxt <= LEAVE_W) w_state_next = LOT_OPEN;
      end
      LOT_FULL: begin
        if (i_cnt_nxt < CAP_W) w_state_next = LOT_NEAR;
      end
      default: w_state_next = LOT_OPEN;
    endcase
  end

  assign o_lot_state = r_state;

endmodule

// File: rtl/occupancy_counter.sv
// Saturating car counter driven by entry/exit pulses, with derived status
// flags, sticky overflow/underflow errors and the lot-status FSM.
module occupancy_counter
  import parking_pkg::*;
#(
  parameter int CAPACITY  = DEF_CAPACITY,
  parameter int NEAR_FULL = DEF_NEAR_FULL,
  parameter int HYST      = DEF_HYST
) (
  input  logic              clk,
  input  logic              reset_n,
  occupancy_counter_if.slave bus
);

  localparam int W = $clog2(CAPACITY + 1);
  localparam logic [W-1:0] CAP_W = W'(CAPACITY);
  localparam logic [W-1:0] ONE_W = W'(1);

  logic [W-1:0] r_count;
  logic [W-1:0] r_free;
  logic         r_empty;
  logic         r_full;
  logic         r_ovf;
  logic         r_unf;

  logic [W-1:0] w_cnt_nxt;
  logic         w_ovf_evt;
  logic         w_unf_evt;

  // Next count: a lone pulse moves by one unless it would leave [0, CAPACITY];
  // simultaneous pulses cancel and never raise an error.
  always_comb begin
    w_cnt_nxt = r_count;
    w_ovf_evt = 1'b0;
    w_unf_evt = 1'b0;
    if (bus.inc && !bus.dec) begin
      if (r_full) w_ovf_evt = 1'b1;
      else        w_cnt_nxt = r_count + ONE_W;
    end else if (bus.dec && !bus.inc) begin
      if (r_empty) w_unf_evt = 1'b1;
      else         w_cnt_nxt = r_count - ONE_W;
    end
  end

  // Count and flags all load from the next count so they stay coherent.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
      r_free  <= CAP_W;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
    end else begin
      r_count <= w_cnt_nxt;
      r_free  <= CAP_W - w_cnt_nxt;
      r_empty <= (w_cnt_nxt == '0);
      r_full  <= (w_cnt_nxt == CAP_W);
    end
  end

  // Sticky errors; a fresh error outranks a clear in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_ovf <= w_ovf_evt | (r_ovf & ~bus.clr_err);
      r_unf <= w_unf_evt | (r_unf & ~bus.clr_err);
    end
  end

  lot_status_fsm #(
    .CAPACITY  (CAPACITY),
    .NEAR_FULL (NEAR_FULL),
    .HYST      (HYST),
    .W         (W)
  ) u_lot_status_fsm (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_cnt_nxt   (w_cnt_nxt),
    .o_lot_state (bus.lot_state)
  );

  assign bus.count         = r_count;
  assign bus.free          = r_free;
  assign bus.empty         = r_empty;
  assign bus.full          = r_full;
  assign bus.overflow_err  = r_ovf;
  assign bus.underflow_err = r_unf;

endmodule
